// File: rtl/ejection_sink.sv
// Terminal flit consumer on a router ejection port: per-VC packet framing, delayed credit return, counters.
// Optional destination check enabled by defining EJECT_DST_CHECK_EN.
module ejection_sink #(
    parameter int NUM_VC       = 4,
    parameter int VC_W         = 2,
    parameter int DST_W        = 4,
    parameter int MY_ID        = 0,
    parameter int CREDIT_DELAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flit_full,
    input  logic [VC_W-1:0]   flit_vc,
    input  logic              flit_head,
    input  logic              flit_tail,
    input  logic [DST_W-1:0]  flit_dst,
    output logic              cr_valid,
    output logic [VC_W-1:0]   cr_vc,
    output logic [31:0]       flit_count,
    output logic [31:0]       pkt_count,
    output logic [15:0]       err_count,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic [NUM_VC-1:0] dbg_vc_open
);

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_OPEN = 1'b1
    } vc_state_e;

    vc_state_e vc_state_q [NUM_VC];
    vc_state_e vc_state_d [NUM_VC];

    logic [CREDIT_DELAY-1:0] cr_v_q, cr_v_d;
    logic [VC_W-1:0]         cr_vc_q [CREDIT_DELAY];
    logic [VC_W-1:0]         cr_vc_d [CREDIT_DELAY];

    logic [31:0] flit_count_q, flit_count_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        busy_q, busy_d;

    logic        vc_ok;
    vc_state_e   cur_state;
    vc_state_e   cur_next;
    logic [1:0]  frame_code;
    logic        pkt_inc;
    logic        dst_err;

`ifdef EJECT_DST_CHECK_EN
    assign dst_err = flit_full && (flit_dst != DST_W'(MY_ID));
`else
    logic unused_dst;
    assign unused_dst = ^flit_dst;
    assign dst_err    = 1'b0;
`endif

    // Framing: a head always starts a fresh packet, abandoning any open one.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            vc_state_d[i] = vc_state_q[i];
        end
        vc_ok      = 1'b0;
        cur_state  = VC_IDLE;
        cur_next   = VC_IDLE;
        frame_code = 2'd0;
        pkt_inc    = 1'b0;

        for (int i = 0; i < NUM_VC; i++) begin
            if (int'(flit_vc) == i) begin
                vc_ok     = 1'b1;
                cur_state = vc_state_q[i];
            end
        end
        cur_next = cur_state;

        if (flit_full && vc_ok) begin
            if (flit_head) begin
                if (cur_state == VC_OPEN) frame_code = 2'd2;
                pkt_inc  = flit_tail;
                cur_next = flit_tail ? VC_IDLE : VC_OPEN;
            end else if (cur_state == VC_IDLE) begin
                frame_code = 2'd1;
            end else if (flit_tail) begin
                pkt_inc  = 1'b1;
                cur_next = VC_IDLE;
            end
            for (int i = 0; i < NUM_VC; i++) begin
                if (int'(flit_vc) == i) vc_state_d[i] = cur_next;
            end
        end
    end

    always_comb begin
        flit_count_d = flit_full ? flit_count_q + 32'd1 : flit_count_q;
        pkt_count_d  = pkt_inc ? pkt_count_q + 32'd1 : pkt_count_q;
        err_count_d  = err_count_q;
        err_code_d   = err_code_q;
        // Framing errors take priority in err_code; a flit counts as one error.
        if (frame_code != 2'd0) begin
            err_code_d = frame_code;
        end else if (dst_err) begin
            err_code_d = 2'd3;
        end
        if ((frame_code != 2'd0 || dst_err) && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
        end
        busy_d = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (vc_state_d[i] == VC_OPEN) busy_d = 1'b1;
        end
    end

    always_comb begin
        cr_v_d     = '0;
        cr_v_d[0]  = flit_full;
        cr_vc_d[0] = flit_full ? flit_vc : '0;
        for (int i = 1; i < CREDIT_DELAY; i++) begin
            cr_v_d[i]  = cr_v_q[i-1];
            cr_vc_d[i] = cr_vc_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                vc_state_q[i] <= VC_IDLE;
            end
            for (int i = 0; i < CREDIT_DELAY; i++) begin
                cr_vc_q[i] <= '0;
            end
            cr_v_q       <= '0;
            flit_count_q <= '0;
            pkt_count_q  <= '0;
            err_count_q  <= '0;
            err_code_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                vc_state_q[i] <= vc_state_d[i];
            end
            for (int i = 0; i < CREDIT_DELAY; i++) begin
                cr_vc_q[i] <= cr_vc_d[i];
            end
            cr_v_q       <= cr_v_d;
            flit_count_q <= flit_count_d;
            pkt_count_q  <= pkt_count_d;
            err_count_q  <= err_count_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            dbg_vc_open[i] = (vc_state_q[i] == VC_OPEN);
        end
    end

    assign cr_valid   = cr_v_q[CREDIT_DELAY-1];
    assign cr_vc      = cr_vc_q[CREDIT_DELAY-1];
    assign flit_count = flit_count_q;
    assign pkt_count  = pkt_count_q;
    assign err_count  = err_count_q;
    assign err_code   = err_code_q;
    assign busy       = busy_q;

endmodule
